// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, ALU codes,
// T-state encodings and the instruction-class enum.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,
                         OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_AND  = 5'd5,
                         OP_OR   = 5'd6,  OP_ROR  = 5'd7,  OP_ROL  = 5'd8,
                         OP_SHR  = 5'd9,  OP_SHRA = 5'd10, OP_SHL  = 5'd11,
                         OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14,
                         OP_MUL  = 5'd15, OP_DIV  = 5'd16, OP_NEG  = 5'd17,
                         OP_NOT  = 5'd18, OP_NOP  = 5'd25, OP_HALT = 5'd26;

  localparam logic [4:0] ALU_NOP  = 5'd0,  ALU_ADD = 5'd1,  ALU_SUB = 5'd2,
                         ALU_AND  = 5'd3,  ALU_OR  = 5'd4,  ALU_ROR = 5'd5,
                         ALU_ROL  = 5'd6,  ALU_SHR = 5'd7,  ALU_SHRA = 5'd8,
                         ALU_SHL  = 5'd9,  ALU_MUL = 5'd10, ALU_DIV = 5'd11,
                         ALU_NEG  = 5'd12, ALU_NOT = 5'd13;

  localparam logic [3:0] S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T1W = 4'd3,
                         S_T2   = 4'd4, S_T3 = 4'd5, S_T4 = 4'd6, S_T5  = 4'd7,
                         S_T6   = 4'd8, S_T7 = 4'd9, S_HALT = 4'd10;

  typedef enum logic [3:0] {
    CL_RTYPE, CL_IMM, CL_UNARY, CL_MULDIV, CL_LD, CL_LDI, CL_ST, CL_NOP, CL_HALT
  } op_class_e;

endpackage

// File: rtl/control_sequencer_if.sv
// Datapath control bus: IR and memory handshake in, every strobe and the ALU
// opcode out. master = control unit, slave = datapath.
interface control_sequencer_if;
  logic [31:0] ir;
  logic        mem_ready;
  logic        PCout, PCin, IncPC, MARin;
  logic        MDRin, MDRout, MDRread, MDRwrite;
  logic        IRin, RYin, RZinLo, RZinHi, RZoutLo, RZoutHi;
  logic        LOin, HIin, Cout;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0]  alu_op;

  modport master (
    input  ir, mem_ready,
    output PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, MDRwrite,
           IRin, RYin, RZinLo, RZinHi, RZoutLo, RZoutHi, LOin, HIin, Cout,
           Gra, Grb, Grc, Rin, Rout, BAout, alu_op
  );

  modport slave (
    output ir, mem_ready,
    input  PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, MDRwrite,
           IRin, RYin, RZinLo, RZinHi, RZoutLo, RZoutHi, LOin, HIin, Cout,
           Gra, Grb, Grc, Rin, Rout, BAout, alu_op
  );
endinterface

// File: rtl/cu_decode.sv
// Combinational opcode decoder: opcode -> instruction class, ALU op, illegal.
module cu_decode import cpu_ctrl_pkg::*; #(
  parameter int unsigned OPW = 5
) (
  input  logic [OPW-1:0] opcode,
  output op_class_e      op_class,
  output logic [4:0]     alu_op,
  output logic           illegal
);

  always_comb begin
    op_class = CL_NOP;
    alu_op   = ALU_NOP;
    illegal  = 1'b0;
    case (opcode)
      OP_LD:   begin op_class = CL_LD;     alu_op = ALU_ADD;  end
      OP_LDI:  begin op_class = CL_LDI;    alu_op = ALU_ADD;  end
      OP_ST:   begin op_class = CL_ST;     alu_op = ALU_ADD;  end
      OP_ADD:  begin op_class = CL_RTYPE;  alu_op = ALU_ADD;  end
      OP_SUB:  begin op_class = CL_RTYPE;  alu_op = ALU_SUB;  end
      OP_AND:  begin op_class = CL_RTYPE;  alu_op = ALU_AND;  end
      OP_OR:   begin op_class = CL_RTYPE;  alu_op = ALU_OR;   end
      OP_ROR:  begin op_class = CL_RTYPE;  alu_op = ALU_ROR;  end
      OP_ROL:  begin op_class = CL_RTYPE;  alu_op = ALU_ROL;  end
      OP_SHR:  begin op_class = CL_RTYPE;  alu_op = ALU_SHR;  end
      OP_SHRA: begin op_class = CL_RTYPE;  alu_op = ALU_SHRA; end
      OP_SHL:  begin op_class = CL_RTYPE;  alu_op = ALU_SHL;  end
      OP_ADDI: begin op_class = CL_IMM;    alu_op = ALU_ADD;  end
      OP_ANDI: begin op_class = CL_IMM;    alu_op = ALU_AND;  end
      OP_ORI:  begin op_class = CL_IMM;    alu_op = ALU_OR;   end
      OP_MUL:  begin op_class = CL_MULDIV; alu_op = ALU_MUL;  end
      OP_DIV:  begin op_class = CL_MULDIV; alu_op = ALU_DIV;  end
      OP_NEG:  begin op_class = CL_UNARY;  alu_op = ALU_NEG;  end
      OP_NOT:  begin op_class = CL_UNARY;  alu_op = ALU_NOT;  end
      OP_NOP:  op_class = CL_NOP;
      OP_HALT: op_class = CL_HALT;
      default: illegal = 1'b1;   // executes as nop
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute T-state sequencer for the bus-based CPU datapath.
// Optional CU_MEM_TIMEOUT_EN: bounded memory waits with sticky mem_err + HALT.
module control_sequencer import cpu_ctrl_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned OPW            = 5
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  control_sequencer_if.master bus,
  output logic                halted,
  output logic                illegal_op,
`ifdef CU_MEM_TIMEOUT_EN
  output logic                mem_err,
`endif
  output logic [3:0]          tstate
);

  logic [3:0] state, state_nxt;
  op_class_e  op_class;
  logic [4:0] dec_alu;
  logic       dec_illegal;
  logic       last_state;
  logic       unused_ir_bits;

  assign unused_ir_bits = ^bus.ir[31-OPW:0];

  cu_decode #(.OPW(OPW)) u_decode (
    .opcode   (bus.ir[31 -: OPW]),
    .op_class (op_class),
    .alu_op   (dec_alu),
    .illegal  (dec_illegal)
  );

`ifdef CU_MEM_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] wait_cnt;
  logic          in_wait, timeout_hit;

  assign in_wait = (state == S_T1W) ||
                   (state == S_T6 && op_class == CL_LD) ||
                   (state == S_T7 && op_class == CL_ST);
  assign timeout_hit = in_wait && !bus.mem_ready &&
                       (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      wait_cnt <= (in_wait && !bus.mem_ready && !timeout_hit) ? wait_cnt + 1'b1 : '0;
      if (timeout_hit) mem_err <= 1'b1;
    end
  end
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Final T-state of each class; ld/st only ever reach T7.
  always_comb begin
    last_state = 1'b0;
    case (state)
      S_T3:    last_state = (op_class == CL_NOP);
      S_T4:    last_state = (op_class == CL_UNARY);
      S_T5:    last_state = (op_class inside {CL_RTYPE, CL_IMM, CL_LDI});
      S_T6:    last_state = (op_class == CL_MULDIV);
      S_T7:    last_state = (op_class == CL_LD) || bus.mem_ready;
      default: last_state = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (run) state_nxt = S_T0;
      S_T0:        state_nxt = S_T1;
      S_T1, S_T1W: state_nxt = bus.mem_ready ? S_T2 : S_T1W;
      S_T2:        state_nxt = S_T3;
      S_T3:        state_nxt = (op_class == CL_HALT) ? S_HALT : S_T4;
      S_T4, S_T5:  state_nxt = state + 4'd1;
      S_T6:        if (op_class != CL_LD || bus.mem_ready) state_nxt = S_T7;
      S_T7, S_HALT: state_nxt = state;
      default:     state_nxt = S_IDLE;
    endcase
    if (last_state) state_nxt = run ? S_T0 : S_IDLE;
`ifdef CU_MEM_TIMEOUT_EN
    if (timeout_hit) state_nxt = S_HALT;
`endif
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= S_IDLE;
    else        state <= state_nxt;
  end

  assign tstate = state;
  assign halted = (state == S_HALT);

  always_comb begin
    bus.PCout   = 1'b0; bus.PCin    = 1'b0; bus.IncPC   = 1'b0; bus.MARin    = 1'b0;
    bus.MDRin   = 1'b0; bus.MDRout  = 1'b0; bus.MDRread = 1'b0; bus.MDRwrite = 1'b0;
    bus.IRin    = 1'b0; bus.RYin    = 1'b0; bus.RZinLo  = 1'b0; bus.RZinHi   = 1'b0;
    bus.RZoutLo = 1'b0; bus.RZoutHi = 1'b0; bus.LOin    = 1'b0; bus.HIin     = 1'b0;
    bus.Cout    = 1'b0; bus.Gra     = 1'b0; bus.Grb     = 1'b0; bus.Grc      = 1'b0;
    bus.Rin     = 1'b0; bus.Rout    = 1'b0; bus.BAout   = 1'b0;
    bus.alu_op  = ALU_NOP;
    illegal_op  = 1'b0;
    case (state)
      S_T0:  begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.RZinLo = 1'b1; end
      S_T1:  begin bus.RZoutLo = 1'b1; bus.PCin = 1'b1; bus.MDRread = 1'b1; bus.MDRin = 1'b1; end
      S_T1W: begin bus.MDRread = 1'b1; bus.MDRin = 1'b1; end
      S_T2:  begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
      S_T3: begin
        illegal_op = dec_illegal;
        case (op_class)
          CL_RTYPE, CL_IMM: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.RYin = 1'b1; end
          CL_UNARY: begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.RZinLo = 1'b1; bus.alu_op = dec_alu;
          end
          CL_MULDIV: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.RYin = 1'b1; end
          CL_LD, CL_LDI, CL_ST: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.RYin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (op_class)
          CL_RTYPE: begin
            bus.Grc = 1'b1; bus.Rout = 1'b1; bus.RZinLo = 1'b1; bus.alu_op = dec_alu;
          end
          CL_IMM, CL_LD, CL_LDI, CL_ST: begin
            bus.Cout = 1'b1; bus.RZinLo = 1'b1; bus.alu_op = dec_alu;
          end
          CL_UNARY: begin bus.RZoutLo = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          CL_MULDIV: begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.RZinLo = 1'b1; bus.RZinHi = 1'b1;
            bus.alu_op = dec_alu;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (op_class)
          CL_RTYPE, CL_IMM, CL_LDI: begin bus.RZoutLo = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          CL_MULDIV:   begin bus.RZoutLo = 1'b1; bus.LOin = 1'b1; end
          CL_LD, CL_ST: begin bus.RZoutLo = 1'b1; bus.MARin = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (op_class)
          CL_MULDIV: begin bus.RZoutHi = 1'b1; bus.HIin = 1'b1; end
          CL_LD:     begin bus.MDRread = 1'b1; bus.MDRin = 1'b1; end
          CL_ST:     begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
          default: ;
        endcase
      end
      S_T7: begin
        case (op_class)
          CL_LD:   begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          CL_ST:   bus.MDRwrite = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle vector table plus
// hand-written sequences for memory waits, reset, and halt.
module tb_control_sequencer;
  import cpu_ctrl_pkg::*;

  logic       clock = 1'b0;
  logic       clear, run, halted, illegal_op;
  logic [3:0] tstate;

  control_sequencer_if bus();

  control_sequencer #(.TIMEOUT_CYCLES(16), .OPW(5)) dut (
    .clock      (clock),
    .clear      (clear),
    .run        (run),
    .bus        (bus.master),
    .halted     (halted),
    .illegal_op (illegal_op),
    .tstate     (tstate)
  );

  always #5 clock = ~clock;

  localparam logic [24:0] F_PCOUT   = 25'b1 << 0,  F_PCIN    = 25'b1 << 1,
                          F_INCPC   = 25'b1 << 2,  F_MARIN   = 25'b1 << 3,
                          F_MDRIN   = 25'b1 << 4,  F_MDROUT  = 25'b1 << 5,
                          F_MDRREAD = 25'b1 << 6,  F_MDRWR   = 25'b1 << 7,
                          F_IRIN    = 25'b1 << 8,  F_RYIN    = 25'b1 << 9,
                          F_RZINLO  = 25'b1 << 10, F_RZINHI  = 25'b1 << 11,
                          F_RZOUTLO = 25'b1 << 12, F_RZOUTHI = 25'b1 << 13,
                          F_LOIN    = 25'b1 << 14, F_HIIN    = 25'b1 << 15,
                          F_COUT    = 25'b1 << 16, F_GRA     = 25'b1 << 17,
                          F_GRB     = 25'b1 << 18, F_GRC     = 25'b1 << 19,
                          F_RIN     = 25'b1 << 20, F_ROUT    = 25'b1 << 21,
                          F_BAOUT   = 25'b1 << 22, F_ILL     = 25'b1 << 23,
                          F_HALT    = 25'b1 << 24;

  localparam logic [31:0] IR_SHRA = 32'h522B8000, IR_ADD = 32'h18000000,
                          IR_ADDI = 32'h60000000, IR_NEG = 32'h88000000,
                          IR_MUL  = 32'h78000000, IR_LDI = 32'h08000000,
                          IR_LD   = 32'h00000000, IR_ST  = 32'h10000000,
                          IR_NOP  = 32'hC8000000, IR_HALT = 32'hD0000000,
                          IR_BAD  = 32'hF8000000;

  typedef struct {
    logic        run;
    logic        mr;
    logic [31:0] ir;
    logic [3:0]  st;
    logic [24:0] fl;
    logic [4:0]  alu;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [24:0] cur_flags();
    return {halted, illegal_op, bus.BAout, bus.Rout, bus.Rin, bus.Grc, bus.Grb,
            bus.Gra, bus.Cout, bus.HIin, bus.LOin, bus.RZoutHi, bus.RZoutLo,
            bus.RZinHi, bus.RZinLo, bus.RYin, bus.IRin, bus.MDRwrite, bus.MDRread,
            bus.MDRout, bus.MDRin, bus.MARin, bus.IncPC, bus.PCin, bus.PCout};
  endfunction

  function automatic void add(input logic r, input logic m, input logic [31:0] i,
                              input logic [3:0] s, input logic [24:0] f,
                              input logic [4:0] a);
    vec_t v;
    v.run = r; v.mr = m; v.ir = i; v.st = s; v.fl = f; v.alu = a;
    tbl.push_back(v);
  endfunction

  function automatic void add_fetch(input logic [31:0] i);
    add(1'b1, 1'b1, i, S_T0, F_PCOUT | F_MARIN | F_INCPC | F_RZINLO, ALU_NOP);
    add(1'b1, 1'b1, i, S_T1, F_RZOUTLO | F_PCIN | F_MDRREAD | F_MDRIN, ALU_NOP);
    add(1'b1, 1'b1, i, S_T2, F_MDROUT | F_IRIN, ALU_NOP);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n_w, n_w_ok, n_pc, ir_c, n_wr, end_cyc;
    logic [24:0] st6;
    logic found;

    add(1'b1, 1'b1, IR_SHRA, S_IDLE, '0, ALU_NOP);
    add_fetch(IR_SHRA);
    add(1'b1, 1'b1, IR_SHRA, S_T3, F_GRB | F_ROUT | F_RYIN, ALU_NOP);
    add(1'b1, 1'b1, IR_SHRA, S_T4, F_GRC | F_ROUT | F_RZINLO, ALU_SHRA);
    add(1'b1, 1'b1, IR_SHRA, S_T5, F_RZOUTLO | F_GRA | F_RIN, ALU_NOP);
    add_fetch(IR_ADDI);
    add(1'b1, 1'b1, IR_ADDI, S_T3, F_GRB | F_ROUT | F_RYIN, ALU_NOP);
    add(1'b1, 1'b1, IR_ADDI, S_T4, F_COUT | F_RZINLO, ALU_ADD);
    add(1'b1, 1'b1, IR_ADDI, S_T5, F_RZOUTLO | F_GRA | F_RIN, ALU_NOP);
    add_fetch(IR_NEG);
    add(1'b1, 1'b1, IR_NEG, S_T3, F_GRB | F_ROUT | F_RZINLO, ALU_NEG);
    add(1'b1, 1'b1, IR_NEG, S_T4, F_RZOUTLO | F_GRA | F_RIN, ALU_NOP);
    add_fetch(IR_MUL);
    add(1'b1, 1'b1, IR_MUL, S_T3, F_GRA | F_ROUT | F_RYIN, ALU_NOP);
    add(1'b1, 1'b1, IR_MUL, S_T4, F_GRB | F_ROUT | F_RZINLO | F_RZINHI, ALU_MUL);
    add(1'b1, 1'b1, IR_MUL, S_T5, F_RZOUTLO | F_LOIN, ALU_NOP);
    add(1'b1, 1'b1, IR_MUL, S_T6, F_RZOUTHI | F_HIIN, ALU_NOP);
    add_fetch(IR_LDI);
    add(1'b1, 1'b1, IR_LDI, S_T3, F_GRB | F_BAOUT | F_RYIN, ALU_NOP);
    add(1'b1, 1'b1, IR_LDI, S_T4, F_COUT | F_RZINLO, ALU_ADD);
    add(1'b1, 1'b1, IR_LDI, S_T5, F_RZOUTLO | F_GRA | F_RIN, ALU_NOP);
    add_fetch(IR_LD);
    add(1'b1, 1'b1, IR_LD, S_T3, F_GRB | F_BAOUT | F_RYIN, ALU_NOP);
    add(1'b1, 1'b1, IR_LD, S_T4, F_COUT | F_RZINLO, ALU_ADD);
    add(1'b1, 1'b1, IR_LD, S_T5, F_RZOUTLO | F_MARIN, ALU_NOP);
    add(1'b1, 1'b1, IR_LD, S_T6, F_MDRREAD | F_MDRIN, ALU_NOP);
    add(1'b1, 1'b1, IR_LD, S_T7, F_MDROUT | F_GRA | F_RIN, ALU_NOP);
    add_fetch(IR_BAD);
    add(1'b0, 1'b1, IR_BAD, S_T3, F_ILL, ALU_NOP);
    add(1'b0, 1'b1, IR_NOP, S_IDLE, '0, ALU_NOP);

    clear = 1'b0; run = 1'b0; bus.mem_ready = 1'b1; bus.ir = '0;
    #3;
    check("reset_tstate", tstate, S_IDLE);
    check("reset_flags", cur_flags(), '0);
    check("reset_alu", bus.alu_op, ALU_NOP);
    clear = 1'b1;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      run = tbl[i].run; bus.mem_ready = tbl[i].mr; bus.ir = tbl[i].ir;
      #1;
      check($sformatf("vec%0d", i), {tstate, bus.alu_op, cur_flags()},
            {tbl[i].st, tbl[i].alu, tbl[i].fl});
      tick();
    end

    // Fetch with mem_ready low in T1 and two T1W cycles.
    n_w = 0; n_w_ok = 0; n_pc = 0; ir_c = -1;
    bus.ir = IR_NOP;
    for (int c = 0; c < 10; c++) begin
      run = (c == 0);
      bus.mem_ready = !(c >= 2 && c <= 4);
      #1;
      if (tstate == S_T1W) begin
        n_w++;
        if (bus.MDRread && bus.MDRin && !bus.PCin) n_w_ok++;
      end
      if (bus.PCin) n_pc++;
      if (bus.IRin) ir_c = c;
      tick();
    end
    check("fetchwait_t1w_cycles", n_w, 3);
    check("fetchwait_t1w_strobes", n_w_ok, 3);
    check("fetchwait_pcin_count", n_pc, 1);
    check("fetchwait_irin_cycle", ir_c, 6);
    check("fetchwait_end_idle", tstate, S_IDLE);

    // st with two wait cycles in T7.
    n_wr = 0; end_cyc = -1; st6 = '0;
    bus.ir = IR_ST; run = 1'b1;
    for (int c = 0; c < 40; c++) begin
      bus.mem_ready = !(c == 8 || c == 9);
      #1;
      if (c > 1 && tstate == S_T0) begin
        end_cyc = c;
        break;
      end
      if (bus.MDRwrite) n_wr++;
      if (tstate == S_T6) st6 = cur_flags();
      tick();
    end
    check("st_mdrwrite_cycles", n_wr, 3);
    check("st_total_cycles", end_cyc - 1, 10);
    check("st_t6_strobes", st6, F_GRA | F_ROUT | F_MDRIN);
    check("st_back_to_t0", tstate, S_T0);

    // Asynchronous reset in the middle of an add.
    bus.ir = IR_ADD; bus.mem_ready = 1'b1; run = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    check("add_reached_t4", tstate, S_T4);
    clear = 1'b0;
    #1;
    check("midreset_tstate", tstate, S_IDLE);
    check("midreset_outputs", {bus.alu_op, cur_flags()}, '0);
    clear = 1'b1;
    tick();
    check("postreset_t0", tstate, S_T0);

    // halt: sticky regardless of run, left only through clear.
    bus.ir = IR_HALT;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (tstate == S_HALT) found = 1'b1;
    end
    check("halt_entered", found, 1'b1);
    for (int k = 0; k < 6; k++) begin
      run = k[0];
      #1;
      check($sformatf("halt_hold%0d", k), {tstate, bus.alu_op, cur_flags()},
            {S_HALT, ALU_NOP, F_HALT});
      tick();
    end
    run = 1'b0;
    clear = 1'b0;
    #1;
    check("halt_clear_outputs", {tstate, bus.alu_op, cur_flags()}, '0);
    clear = 1'b1;
    tick();
    check("halt_clear_idle", {tstate, cur_flags()}, {S_IDLE, 25'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

endmodule
